score_display_mux: RTL and testbench
====================================

# score_display_mux

Drives the Pong score onto the board's 4-digit multiplexed seven-segment display. Latches the two player scores (0–99), converts each to two BCD digits with a sequential shift-add-3 converter, and time-multiplexes the four digits. Each cycle it presents one 4-bit digit code to the downstream `binary_to_segment` decoder, together with the matching active-low anode select. Tens digits that are zero are blanked by emitting code 4'hF, which the decoder renders as all segments off.

## Interface
- `REFRESH_DIV`, 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz); must be ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `score_left`  in  7  left player score, unsigned; values > 99 saturate to 99.
- `score_right`  in  7  right player score, unsigned; values > 99 saturate to 99.
- `score_load`  in  1  single-cycle request to capture both scores.
- `blank`  in  1  1 = all anodes off; scanning continues.
- `busy`  out  1  conversion in progress; `score_load` is ignored while high.
- `digit`  out  4  code for `binary_to_segment`: 0–9 = numeral, 4'hF = blank.
- `an`  out  4  anode enables, active-low; `an[0]` is the rightmost digit.

## Operation
- Reset (`rst_n`=0 at a clock edge):
  - prescaler = 0, scan index = 0, `busy` = 0.
  - All four displayed BCD registers = 0, converter state cleared.
  - Outputs after reset: `an` = 4'b1110, `digit` = 4'd0. The display shows "0" on digit 2 and digit 0; the tens digits are blanked.
  - Reset asserted mid-conversion aborts the conversion. The displayed registers return to 0 and the aborted result is never written.
- Load:
  - `score_load`=1 with `busy`=0 captures the saturated `score_left` and `score_right` into shift registers and sets `busy`.
  - `score_load` while `busy`=1 is dropped. It is not queued.
- Conversion: two converters run in parallel, one per score. Each is the 7-bit double-dabble: 7 iterations, and every iteration does the following.
  - Add 3 to each BCD nibble that is ≥ 5.
  - Shift the {tens, ones, binary} register left by 1.
  - After the 7th iteration, tens and ones are written to the displayed registers and `busy` clears on that same edge.
  - Displayed registers keep their old values for the whole conversion (no flicker).
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps. When it wraps, the scan index advances 0→1→2→3→0.
  - Index 0: `an`=1110, `digit` = right ones.
  - Index 1: `an`=1101, `digit` = right tens, or 4'hF if that tens digit is 0.
  - Index 2: `an`=1011, `digit` = left ones.
  - Index 3: `an`=0111, `digit` = left tens, or 4'hF if that tens digit is 0.
- Blank: `blank`=1 forces `an`=4'b1111. `digit`, the scan index and the prescaler continue unchanged.
- `an` and `digit` are decoded only from registers (scan index, displayed registers) plus `blank`. No other input has a combinational path to them.

## Timing
- Load latency:
  - `score_load` is sampled at edge N, and `busy`=1 after edge N.
  - Iterations run on edges N+1..N+7, and the result is written at edge N+7.
  - So `busy` is high for exactly 7 cycles and the new value is visible from the cycle after edge N+7.
  - Earliest accepted back-to-back load is at edge N+8.
- The scan index changes on the edge where the prescaler goes from REFRESH_DIV-1 to 0. `an` and `digit` change in the same cycle.
- A full scan period is 4×REFRESH_DIV cycles.
- Loads and scanning are independent. A result write that coincides with a scan-index change shows the new value immediately on the newly selected digit.

## Test plan
- Reset, REFRESH_DIV=4: hold `rst_n`=0 for 2 cycles, then release.
  - `an` steps 1110,1101,1011,0111 every 4 cycles.
  - `digit` steps 0,F,0,F.
  - `busy`=0.
- Load left=42, right=7:
  - `busy` is high for exactly 7 cycles.
  - The following scan gives `digit` 7,F,2,4.
- Load left=120, right=99 (saturation): the scan gives 9,9,9,9.
- Repeated load:
  - Pulse a second load (left=1, right=1) 3 cycles after a first load (left=55, right=66).
  - The second load is ignored and the display shows 6,6,5,5.
  - Once `busy` has fallen, a third load (left=10, right=0) is accepted and shows 0,F,0,1.
- `blank`=1 for 10 cycles: `an`=1111 throughout. After release the scan index has still advanced on schedule.
- Reset mid-conversion:
  - Displayed value is 33/44; load 88/88, then drop `rst_n` at cycle N+4.
  - After release: 0,F,0,F and `busy`=0. The value 88 never appears.

Source files
------------

// File: rtl/score_display_mux.sv
// Latches two 0-99 scores, converts each to BCD with a 7-step double-dabble and scans four 7-seg digits.
// Load-to-display latency 8 edges (busy for 7 cycles); no backpressure, loads while busy are dropped.
module score_display_mux #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] score_left,
    input  logic [6:0] score_right,
    input  logic       score_load,
    input  logic       blank,
    output logic       busy,
    output logic [3:0] digit,
    output logic [3:0] an
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    // {tens, ones, binary} working register of one converter
    typedef logic [14:0] dd_t;

    function automatic dd_t dd_step(input dd_t s);
        logic [3:0] t;
        logic [3:0] o;
        t = s[14:11];
        o = s[10:7];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t[2:0], o, s[6:0], 1'b0};
    endfunction

    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    scan_q, scan_d;
    logic [2:0]    iter_q, iter_d;
    dd_t           sr_l_q, sr_l_d, sr_r_q, sr_r_d;
    logic [3:0]    disp_lt_q, disp_lt_d, disp_lo_q, disp_lo_d;
    logic [3:0]    disp_rt_q, disp_rt_d, disp_ro_q, disp_ro_d;
    dd_t           step_l, step_r;
    logic          wrap;
    logic [3:0]    an_sel;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        scan_d    = scan_q;
        iter_d    = iter_q;
        sr_l_d    = sr_l_q;
        sr_r_d    = sr_r_q;
        disp_lt_d = disp_lt_q;
        disp_lo_d = disp_lo_q;
        disp_rt_d = disp_rt_q;
        disp_ro_d = disp_ro_q;
        step_l    = dd_step(sr_l_q);
        step_r    = dd_step(sr_r_q);
        wrap      = (presc_q == PRESC_MAX);

        presc_d = wrap ? '0 : presc_q + 1'b1;
        if (wrap) scan_d = scan_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                if (score_load) begin
                    sr_l_d  = {8'd0, sat99(score_left)};
                    sr_r_d  = {8'd0, sat99(score_right)};
                    iter_d  = 3'd0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                sr_l_d = step_l;
                sr_r_d = step_r;
                iter_d = iter_q + 3'd1;
                // Final iteration: commit straight from the step result so busy drops on this edge
                if (iter_q == 3'd6) begin
                    disp_lt_d = step_l[14:11];
                    disp_lo_d = step_l[10:7];
                    disp_rt_d = step_r[14:11];
                    disp_ro_d = step_r[10:7];
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            scan_q    <= 2'd0;
            iter_q    <= 3'd0;
            sr_l_q    <= '0;
            sr_r_q    <= '0;
            disp_lt_q <= 4'd0;
            disp_lo_q <= 4'd0;
            disp_rt_q <= 4'd0;
            disp_ro_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            scan_q    <= scan_d;
            iter_q    <= iter_d;
            sr_l_q    <= sr_l_d;
            sr_r_q    <= sr_r_d;
            disp_lt_q <= disp_lt_d;
            disp_lo_q <= disp_lo_d;
            disp_rt_q <= disp_rt_d;
            disp_ro_q <= disp_ro_d;
        end
    end

    assign busy = (state_q == S_CONV);

    // Leading-zero tens digits are blanked with code F
    always_comb begin
        an_sel = 4'b1110;
        digit  = disp_ro_q;
        case (scan_q)
            2'd0: begin an_sel = 4'b1110; digit = disp_ro_q; end
            2'd1: begin an_sel = 4'b1101; digit = (disp_rt_q == 4'd0) ? 4'hF : disp_rt_q; end
            2'd2: begin an_sel = 4'b1011; digit = disp_lo_q; end
            2'd3: begin an_sel = 4'b0111; digit = (disp_lt_q == 4'd0) ? 4'hF : disp_lt_q; end
            default: ;
        endcase
        an = blank ? 4'b1111 : an_sel;
    end

endmodule

// File: tb/tb_score_display_mux.sv
// Randomised plus directed bench for score_display_mux; expected {busy,an,digit} per cycle goes through a queue.
module tb_score_display_mux;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] score_left, score_right;
    logic       score_load, blank;
    logic       busy;
    logic [3:0] digit, an;

    score_display_mux #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .score_left(score_left), .score_right(score_right),
        .score_load(score_load), .blank(blank),
        .busy(busy), .digit(digit), .an(an)
    );

    always #5 clk = ~clk;

    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: cycles since reset, remaining busy cycles, shown and pending scores as integers
    int m_edges = 0;
    int m_rem   = 0;
    int m_dl = 0, m_dr = 0, m_pl = 0, m_pr = 0;

    function automatic logic [3:0] tens_code(input int v);
        return (v / 10 == 0) ? 4'hF : 4'(v / 10);
    endfunction

    task automatic cyc(input bit rst, input bit ld, input int l, input int r, input bit blk);
        int idx;
        logic [3:0] e_an, e_dig;
        bit was_busy;
        @(negedge clk);
        rst_n       = ~rst;
        score_load  = ld;
        score_left  = 7'(l);
        score_right = 7'(r);
        blank       = blk;
        if (rst) begin
            m_edges = 0; m_rem = 0; m_dl = 0; m_dr = 0;
        end else begin
            m_edges++;
            was_busy = (m_rem > 0);
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin m_dl = m_pl; m_dr = m_pr; end
            end
            if (ld && !was_busy) begin
                m_pl  = (l > 99) ? 99 : l;
                m_pr  = (r > 99) ? 99 : r;
                m_rem = 7;
            end
        end
        idx = (m_edges / RD) % 4;
        case (idx)
            0: e_dig = 4'(m_dr % 10);
            1: e_dig = tens_code(m_dr);
            2: e_dig = 4'(m_dl % 10);
            default: e_dig = tens_code(m_dl);
        endcase
        e_an = blk ? 4'b1111 : ~(4'b0001 << idx);
        exp_q.push_back({(m_rem > 0), e_an, e_dig});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, $urandom_range(0, 127), $urandom_range(0, 127), 0);
    endtask

    // Monitor: one expectation per clock edge, compared after outputs settle
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({busy, an, digit} !== e) begin
                    errors++;
                    $display("FAIL out cyc=%0d got busy=%b an=%b digit=%h exp busy=%b an=%b digit=%h",
                             cycle, busy, an, digit, e[8], e[7:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; score_load = 1'b0; blank = 1'b0;
        score_left = 7'd0; score_right = 7'd0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(20);

        cyc(0, 1, 42, 7, 0);
        idle(24);

        cyc(0, 1, 120, 99, 0);
        idle(24);

        cyc(0, 1, 55, 66, 0);
        idle(2);
        cyc(0, 1, 1, 1, 0);
        idle(10);
        cyc(0, 1, 10, 0, 0);
        idle(24);

        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
        idle(12);

        cyc(0, 1, 33, 44, 0);
        idle(12);
        cyc(0, 1, 88, 88, 0);
        idle(3);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(20);

        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
                $urandom_range(0, 127), $urandom_range(0, 127), ($urandom_range(0, 7) == 0));

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
